// File: rtl/pixelbox_pkg.sv
// Shared definitions for the pixel delay path: default geometry, tap FSM states
// and the delay clamp helper.
package pixelbox_pkg;

  localparam int PB_DATA_WIDTH     = 24;
  localparam int PB_MAX_DELAY_LAPS = 640;
  localparam int PB_PTR_W          = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } tap_state_e;

  function automatic logic [9:0] clamp_delay(input logic [9:0] req, input logic [9:0] max_d);
    return (req > max_d) ? max_d : req;
  endfunction

endpackage

// File: rtl/delay_tap_reader_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset so it
// maps onto block RAM. A same-address read returns the old contents.
module sdp_ram #(
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // write port and read-first registered read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/delay_tap_reader.sv
// Valid-beat counting delay tap: stores each pixel in a circular RAM and returns the
// pixel from D valid beats earlier, one cycle after each input beat.
module delay_tap_reader
  import pixelbox_pkg::*;
#(
  parameter int DATA_WIDTH     = PB_DATA_WIDTH,
  parameter int MAX_DELAY_LAPS = PB_MAX_DELAY_LAPS,
  parameter int PTR_W          = PB_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [9:0]            delaylap,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_primed,
  output logic [15:0]           o_lap_cnt,
  output logic                  o_err_range
);

  localparam logic [9:0]       MAX_L    = 10'(MAX_DELAY_LAPS);
  localparam logic [PTR_W-1:0] FILL_MAX = PTR_W'(MAX_DELAY_LAPS);

  tap_state_e            state_r, state_n;
  logic [PTR_W-1:0]      fill_r, fill_n, fill_inc_s;
  logic [PTR_W-1:0]      wr_ptr_r, rd_addr_s;
  logic [9:0]            d_r, d_s;
  logic                  change_s, fire_s, wr_en_s, rd_en_s, byp_en_s;
  logic                  valid_r, err_r, primed_r, use_byp_r;
  logic [15:0]           lap_r;
  logic [DATA_WIDTH-1:0] byp_r, ram_q_s;

  // The delay in force this cycle is the clamped request; a change restarts priming.
  assign d_s        = clamp_delay(delaylap, MAX_L);
  assign change_s   = (d_s != d_r);
  assign fill_inc_s = (fill_r == FILL_MAX) ? fill_r : fill_r + PTR_W'(1);
  assign rd_addr_s  = wr_ptr_r - PTR_W'(d_s);
  assign wr_en_s    = i_valid & ~i_flush;
  assign rd_en_s    = fire_s & (d_s != 10'd0);
  assign byp_en_s   = fire_s & (d_s == 10'd0);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state and fill-level logic
  always_comb begin
    state_n = state_r;
    fill_n  = fill_r;
    if (i_flush) begin
      state_n = IDLE;
      fill_n  = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            fill_n  = PTR_W'(1);
            state_n = (d_s == 10'd0) ? RUN : PRIME;
          end else begin
            state_n = IDLE;
          end
        end
        PRIME, RUN: begin
          if (change_s) begin
            state_n = PRIME;
            fill_n  = PTR_W'(i_valid);
          end else if (i_valid) begin
            fill_n  = fill_inc_s;
            state_n = fire_s ? RUN : state_r;
          end else begin
            state_n = state_r;
          end
        end
        default: begin
          state_n = IDLE;
          fill_n  = '0;
        end
      endcase
    end
  end

  // output decode: does this cycle's beat produce a delayed pixel
  always_comb begin
    fire_s = 1'b0;
    if (i_flush || !i_valid) begin
      fire_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    fire_s = (d_s == 10'd0);
        PRIME:   fire_s = !change_s && (fill_r >= PTR_W'(d_s));
        RUN:     fire_s = !change_s;
        default: fire_s = 1'b0;
      endcase
    end
  end

  // datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r    <= '0;
      wr_ptr_r  <= '0;
      d_r       <= 10'd0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      primed_r  <= 1'b0;
      lap_r     <= 16'd0;
      use_byp_r <= 1'b1;
      byp_r     <= '0;
    end else begin
      fill_r   <= fill_n;
      d_r      <= d_s;
      valid_r  <= fire_s;
      primed_r <= (state_n == RUN);
      if (delaylap > MAX_L) begin
        err_r <= 1'b1;
      end
      if (i_flush) begin
        wr_ptr_r <= '0;
        lap_r    <= 16'd0;
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (fire_s) begin
          lap_r     <= lap_r + 16'd1;
          use_byp_r <= byp_en_s;
        end
      end
      if (byp_en_s) begin
        byp_r <= i_data;
      end
    end
  end

  sdp_ram #(.DW(DATA_WIDTH), .AW(PTR_W)) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_ptr_r),
    .wdata (i_data),
    .re    (rd_en_s),
    .raddr (rd_addr_s),
    .rdata (ram_q_s)
  );

  // RAM read data and bypass register both hold between output beats
  assign o_data      = use_byp_r ? byp_r : ram_q_s;
  assign o_valid     = valid_r;
  assign o_primed    = primed_r;
  assign o_lap_cnt   = lap_r;
  assign o_err_range = err_r;

endmodule

// File: tb/tb_delay_tap_reader.sv
// Randomised bench for delay_tap_reader against a beat-history reference model.
module tb_delay_tap_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [23:0] i_data = 24'd0;
  logic [9:0]  delaylap = 10'd0;
  logic        i_flush = 1'b0;
  logic        o_valid, o_primed, o_err_range;
  logic [23:0] o_data;
  logic [15:0] o_lap_cnt;

  int checks = 0;
  int failures = 0;

  delay_tap_reader dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .delaylap(delaylap), .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data),
    .o_primed(o_primed), .o_lap_cnt(o_lap_cnt), .o_err_range(o_err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of beats since the last flush, and the number of beats
  // in the current priming run (restarted by a flush or a delay change once active).
  logic [23:0] m_hist[$];
  int          m_seg, m_dprev, m_lap, m_d;
  bit          m_started, m_err, m_valid, m_primed, m_chg, m_fire;
  logic [23:0] m_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hist.delete();
      m_seg = 0; m_dprev = 0; m_lap = 0; m_started = 0; m_err = 0;
      m_valid = 0; m_primed = 0; m_data = 24'd0;
    end else begin
      m_d = (delaylap > 10'd640) ? 640 : int'(delaylap);
      if (delaylap > 10'd640) m_err = 1;
      if (i_flush) begin
        m_hist.delete();
        m_seg = 0; m_started = 0; m_valid = 0; m_lap = 0; m_primed = 0;
      end else begin
        m_chg  = m_started && (m_d != m_dprev);
        m_fire = 0;
        if (m_chg) begin
          m_seg    = i_valid ? 1 : 0;
          m_primed = 0;
        end else if (i_valid) begin
          m_fire = (m_seg >= m_d);
          if (m_fire) begin
            m_data   = (m_d == 0) ? i_data : m_hist[m_hist.size() - m_d];
            m_lap    = (m_lap + 1) % 65536;
            m_primed = 1;
          end
          m_seg++;
        end
        if (i_valid) begin
          m_hist.push_back(i_data);
          if (m_hist.size() > 1024) void'(m_hist.pop_front());
          m_started = 1;
        end
        m_valid = m_fire;
      end
      m_dprev = m_d;
    end
    #2;
    chk("o_valid",     32'(o_valid),     32'(m_valid));
    chk("o_data",      32'(o_data),      32'(m_data));
    chk("o_primed",    32'(o_primed),    32'(m_primed));
    chk("o_lap_cnt",   32'(o_lap_cnt),   32'(m_lap));
    chk("o_err_range", 32'(o_err_range), 32'(m_err));
  end

  task automatic drive(input bit v, input logic [23:0] dat, input logic [9:0] dl, input bit fl);
    @(negedge clk);
    i_valid = v; i_data = dat; delaylap = dl; i_flush = fl;
  endtask

  int          nbeats;
  logic [9:0]  rdl;
  logic [9:0]  dl_tab [8];

  initial begin
    dl_tab[0] = 10'd0; dl_tab[1] = 10'd1; dl_tab[2] = 10'd2; dl_tab[3] = 10'd3;
    dl_tab[4] = 10'd4; dl_tab[5] = 10'd6; dl_tab[6] = 10'd9; dl_tab[7] = 10'd700;
    repeat (3) @(negedge clk);
    chk("reset_o_data", 32'(o_data), 32'd0);
    rst_n = 1'b1;

    // D=0 bypass
    drive(0, 24'd0, 10'd0, 0);
    for (int i = 1; i <= 5; i++) drive(1, 24'(i), 10'd0, 0);
    drive(0, 24'd0, 10'd0, 0);
    chk("t1_data", 32'(o_data), 32'd5);
    chk("t1_lap", 32'(o_lap_cnt), 32'd5);

    // D=3 priming
    drive(0, 24'd0, 10'd0, 1);
    drive(0, 24'd0, 10'd3, 0);
    for (int i = 1; i <= 10; i++) drive(1, 24'(i), 10'd3, 0);
    drive(0, 24'd0, 10'd3, 0);
    chk("t2_data", 32'(o_data), 32'd7);
    chk("t2_lap", 32'(o_lap_cnt), 32'd7);
    chk("t2_primed", 32'(o_primed), 32'd1);

    // D=640 across the pointer wrap, random gaps
    drive(0, 24'd0, 10'd640, 1);
    nbeats = 0;
    for (int c = 0; c < 3000 && nbeats < 1300; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        drive(1, 24'($urandom), 10'd640, 0);
        nbeats++;
      end else begin
        drive(0, 24'($urandom), 10'd640, 0);
      end
    end
    drive(0, 24'd0, 10'd640, 0);
    chk("t3_lap", 32'(o_lap_cnt), 32'd660);

    // delay change 3 -> 5 in RUN
    drive(0, 24'd0, 10'd3, 1);
    for (int i = 1; i <= 20; i++) drive(1, 24'(100 + i), 10'd3, 0);
    for (int i = 21; i <= 40; i++) drive(1, 24'(100 + i), 10'd5, 0);
    drive(0, 24'd0, 10'd5, 0);
    chk("t4_lap", 32'(o_lap_cnt), 32'd32);
    chk("t4_data", 32'(o_data), 32'd135);

    // out-of-range request is clamped and sticky across flush
    drive(0, 24'd0, 10'd700, 0);
    drive(0, 24'd0, 10'd700, 1);
    drive(0, 24'd0, 10'd700, 0);
    chk("t5_err", 32'(o_err_range), 32'd1);
    for (int i = 0; i < 20; i++) drive(1, 24'($urandom), 10'd700, 0);

    // flush with a beat in RUN
    drive(0, 24'd0, 10'd2, 1);
    for (int i = 1; i <= 6; i++) drive(1, 24'(200 + i), 10'd2, 0);
    drive(1, 24'd77, 10'd2, 1);
    drive(0, 24'd0, 10'd2, 0);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_lap", 32'(o_lap_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) drive(1, 24'(300 + i), 10'd2, 0);

    // random traffic with delay changes and flushes
    rdl = 10'd2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) rdl = dl_tab[$urandom_range(0, 7)];
      drive(1'($urandom_range(0, 2) != 0), 24'($urandom), rdl, ($urandom_range(0, 63) == 0));
    end

    // asynchronous reset mid-stream
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data", 32'(o_data), 32'd0);
    chk("arst_primed", 32'(o_primed), 32'd0);
    chk("arst_lap", 32'(o_lap_cnt), 32'd0);
    chk("arst_err", 32'(o_err_range), 32'd0);
    drive(0, 24'd0, 10'd1, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) drive(1, 24'(400 + i), 10'd1, 0);
    drive(0, 24'd0, 10'd1, 0);
    chk("post_rst_lap", 32'(o_lap_cnt), 32'd5);
    drive(0, 24'd0, 10'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
